// File: rtl/lift_pkg.sv
// Shared types and sizing helper for the lift motion sequencer.
package lift_pkg;

    localparam int FLOOR_W = 4;

    typedef logic [FLOOR_W-1:0] floor_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MOVE = 2'd2,
        DOOR = 2'd3
    } lift_state_t;

    // Width that holds (max(a,b) - 1); never below one bit.
    function automatic int tick_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/lift_tick_timer.sv
// Loadable down-counter paced by the sequencer; shared by the travel and door phases.
module lift_tick_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule

// File: rtl/lift_motion_ctrl.sv
// Per-lift motion sequencer: pops one floor request, steps the car floor by floor, holds the door.
// Optional macro LIFT_ESTOP_EN adds an estop input that freezes motion and door timing.
module lift_motion_ctrl
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS  = 16,
    parameter int FLOOR_TICKS = 8,
    parameter int DOOR_TICKS  = 4,
    parameter int RESET_FLOOR = 0
) (
    input  logic       clk,
    input  logic       rst,
`ifdef LIFT_ESTOP_EN
    input  logic       estop,
`endif
    input  logic       q_empty,
    input  logic [3:0] q_dout,
    output logic       q_rd,
    output logic [3:0] curr_floor,
    output logic       motor_up,
    output logic       motor_dn,
    output logic       door_open,
    output logic       arrived,
    output logic       req_drop,
    output logic       busy
);

    localparam int            TW           = tick_width(FLOOR_TICKS, DOOR_TICKS);
    localparam logic [TW-1:0] FLOOR_RELOAD = TW'(FLOOR_TICKS - 1);
    localparam logic [TW-1:0] DOOR_RELOAD  = TW'(DOOR_TICKS - 1);
    localparam floor_t        RST_FLOOR    = floor_t'(RESET_FLOOR);

    lift_state_t   r_state;
    lift_state_t   w_state_nxt;
    floor_t        r_curr_floor;
    floor_t        r_target;
    floor_t        w_floor_nxt;
    floor_t        w_target_nxt;
    floor_t        w_step_floor;
    logic          w_estop;
    logic          w_going_up;
    logic          w_target_oor;
    logic          w_tmr_load;
    logic          w_tmr_en;
    logic          w_tmr_zero;
    logic [TW-1:0] w_tmr_val;

`ifdef LIFT_ESTOP_EN
    assign w_estop = estop;
`else
    assign w_estop = 1'b0;
`endif

    // Valid targets keep the step direction pointing inward, so the floor never leaves range.
    assign w_going_up   = (r_target > r_curr_floor);
    assign w_step_floor = w_going_up ? (r_curr_floor + floor_t'(1)) : (r_curr_floor - floor_t'(1));
    assign w_target_oor = ({1'b0, r_target} >= 5'(NUM_FLOORS));

    lift_tick_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .en       (w_tmr_en),
        .zero     (w_tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_curr_floor <= RST_FLOOR;
            r_target     <= RST_FLOOR;
        end else begin
            r_curr_floor <= w_floor_nxt;
            r_target     <= w_target_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_floor_nxt  = r_curr_floor;
        w_target_nxt = r_target;
        w_tmr_load   = 1'b0;
        w_tmr_val    = '0;
        w_tmr_en     = 1'b0;
        q_rd         = 1'b0;
        motor_up     = 1'b0;
        motor_dn     = 1'b0;
        door_open    = 1'b0;
        arrived      = 1'b0;
        req_drop     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!q_empty && !w_estop) begin
                    w_target_nxt = q_dout;
                    w_state_nxt  = LOAD;
                end
            end
            LOAD: begin
                q_rd = 1'b1;
                if (w_target_oor) begin
                    req_drop    = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_target == r_curr_floor) begin
                    arrived     = 1'b1;
                    w_state_nxt = DOOR;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = DOOR_RELOAD;
                end else begin
                    w_state_nxt = MOVE;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = FLOOR_RELOAD;
                end
            end
            MOVE: begin
                if (!w_estop) begin
                    motor_up = w_going_up;
                    motor_dn = (r_target < r_curr_floor);
                    w_tmr_en = 1'b1;
                    if (w_tmr_zero) begin
                        w_floor_nxt = w_step_floor;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = FLOOR_RELOAD;
                        if (w_step_floor == r_target) begin
                            arrived     = 1'b1;
                            w_state_nxt = DOOR;
                            w_tmr_val   = DOOR_RELOAD;
                        end
                    end
                end
            end
            DOOR: begin
                door_open = 1'b1;
                if (!w_estop) begin
                    w_tmr_en = 1'b1;
                    if (w_tmr_zero) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign curr_floor = r_curr_floor;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_lift_motion_ctrl.sv
// Self-checking bench for lift_motion_ctrl: per-trip expected-cycle model plus directed literal checks.
// Exercises the estop freeze when built with LIFT_ESTOP_EN.
module tb_lift_motion_ctrl;

    localparam int NF = 10;
    localparam int FT = 8;
    localparam int DT = 4;
    localparam int RF = 0;

    localparam logic [1:0] K_LOAD = 2'd0;
    localparam logic [1:0] K_MOVE = 2'd1;
    localparam logic [1:0] K_DOOR = 2'd2;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       estop   = 1'b0;
    logic       q_empty = 1'b1;
    logic [3:0] q_dout  = 4'd0;
    logic       q_rd;
    logic [3:0] curr_floor;
    logic       motor_up;
    logic       motor_dn;
    logic       door_open;
    logic       arrived;
    logic       req_drop;
    logic       busy;

    logic [3:0]  req_q[$];
    logic [11:0] exp_q[$];
    logic [3:0]  m_floor = 4'(RF);

    int checks = 0;
    int errors = 0;
    int cnt_qrd, cnt_up, cnt_dn, cnt_door, cnt_arr, cnt_drop, cnt_busy;

    lift_motion_ctrl #(
        .NUM_FLOORS  (NF),
        .FLOOR_TICKS (FT),
        .DOOR_TICKS  (DT),
        .RESET_FLOOR (RF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef LIFT_ESTOP_EN
        .estop      (estop),
`endif
        .q_empty    (q_empty),
        .q_dout     (q_dout),
        .q_rd       (q_rd),
        .curr_floor (curr_floor),
        .motor_up   (motor_up),
        .motor_dn   (motor_dn),
        .door_open  (door_open),
        .arrived    (arrived),
        .req_drop   (req_drop),
        .busy       (busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers / drivers ----------------
    function automatic logic [11:0] mk(input logic [1:0] k, input logic [3:0] fl,
                                       input logic qr, input logic up, input logic dn,
                                       input logic dr, input logic ar, input logic dp);
        return {k, fl, qr, up, dn, dr, ar, dp};
    endfunction

    task automatic drive_fifo();
        q_empty = (req_q.size() == 0);
        q_dout  = q_empty ? 4'd0 : req_q[0];
    endtask

    task automatic push(input logic [3:0] t);
        req_q.push_back(t);
        drive_fifo();
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_cnt();
        cnt_qrd = 0; cnt_up = 0; cnt_dn = 0; cnt_door = 0;
        cnt_arr = 0; cnt_drop = 0; cnt_busy = 0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        next_cyc();
        next_cyc();
        while ((busy || (req_q.size() > 0)) && (n < bound)) begin
            next_cyc();
            n++;
        end
        chk("wait_idle_timeout", int'(n >= bound), 0);
    endtask

    // Expected per-cycle outputs of one whole request, from pop to return to idle.
    task automatic build_trip(input logic [3:0] t);
        int f, k, fl;
        logic up;
        f = int'(m_floor);
        if (int'(t) >= NF) begin
            exp_q.push_back(mk(K_LOAD, m_floor, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
            return;
        end
        if (int'(t) == f) begin
            exp_q.push_back(mk(K_LOAD, m_floor, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        end else begin
            exp_q.push_back(mk(K_LOAD, m_floor, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            up = (int'(t) > f);
            k  = up ? (int'(t) - f) : (f - int'(t));
            for (int i = 0; i < k; i++) begin
                fl = up ? (f + i) : (f - i);
                for (int j = 0; j < FT; j++) begin
                    exp_q.push_back(mk(K_MOVE, 4'(fl), 1'b0, up, !up, 1'b0,
                                       (i == k - 1) && (j == FT - 1), 1'b0));
                end
            end
        end
        for (int j = 0; j < DT; j++) begin
            exp_q.push_back(mk(K_DOOR, t, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        end
        m_floor = t;
    endtask

    // ---------------- compare process (scoreboard) ----------------
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            logic [11:0] rec;
            logic [10:0] e;
            logic [10:0] a;
            logic        frz;
            if (exp_q.size() > 0) begin
                rec = exp_q[0];
                frz = estop && (rec[11:10] != K_LOAD);
                e = {rec[9:6], rec[5], rec[4] & ~frz, rec[3] & ~frz, rec[2],
                     rec[1] & ~frz, rec[0], 1'b1};
                if (!frz) begin
                    void'(exp_q.pop_front());
                end
            end else begin
                e = {m_floor, 7'b0};
                if ((req_q.size() > 0) && !estop) begin
                    build_trip(req_q[0]);
                end
            end
            a = {curr_floor, q_rd, motor_up, motor_dn, door_open, arrived, req_drop, busy};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_out t=%0t: got floor=%0d rd/up/dn/door/arr/drop/busy=%b, expected floor=%0d flags=%b",
                         $time, a[10:7], a[6:0], e[10:7], e[6:0]);
            end
            cnt_qrd  += int'(q_rd);
            cnt_up   += int'(motor_up);
            cnt_dn   += int'(motor_dn);
            cnt_door += int'(door_open);
            cnt_arr  += int'(arrived);
            cnt_drop += int'(req_drop);
            cnt_busy += int'(busy);
            if (q_rd && (req_q.size() > 0)) begin
                void'(req_q.pop_front());
                drive_fifo();
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int gap;
        int n;
        clear_cnt();
        @(posedge clk);
        #2;
        chk("rst_floor", int'(curr_floor), RF);
        chk("rst_busy", int'(busy), 0);
        chk("rst_flags", int'({q_rd, motor_up, motor_dn, door_open, arrived, req_drop}), 0);
        rst = 1'b0;

        // 0 -> 3 upward trip
        clear_cnt();
        push(4'd3);
        wait_idle(200);
        chk("up3_qrd", cnt_qrd, 1);
        chk("up3_motor_up", cnt_up, 24);
        chk("up3_door", cnt_door, 4);
        chk("up3_arrived", cnt_arr, 1);
        chk("up3_busy", cnt_busy, 29);
        chk("up3_floor", int'(curr_floor), 3);

        // same-floor request at floor 5
        push(4'd5);
        wait_idle(200);
        chk("at5_floor", int'(curr_floor), 5);
        clear_cnt();
        push(4'd5);
        wait_idle(200);
        chk("same_motor", cnt_up + cnt_dn, 0);
        chk("same_door", cnt_door, 4);
        chk("same_arrived", cnt_arr, 1);
        chk("same_busy", cnt_busy, 5);

        // 3 -> 0 downward trip
        push(4'd3);
        wait_idle(200);
        clear_cnt();
        push(4'd0);
        wait_idle(200);
        chk("dn0_motor_dn", cnt_dn, 24);
        chk("dn0_floor", int'(curr_floor), 0);

        // out-of-range request is popped and dropped
        clear_cnt();
        push(4'hF);
        wait_idle(200);
        chk("drop_pulse", cnt_drop, 1);
        chk("drop_qrd", cnt_qrd, 1);
        chk("drop_busy", cnt_busy, 1);
        chk("drop_floor", int'(curr_floor), 0);

        // back-to-back requests 2 then 4
        clear_cnt();
        push(4'd2);
        push(4'd4);
        wait_idle(300);
        chk("b2b_qrd", cnt_qrd, 2);
        chk("b2b_busy", cnt_busy, 42);
        chk("b2b_floor", int'(curr_floor), 4);

`ifdef LIFT_ESTOP_EN
        // 10-cycle estop during travel stretches the trip by 10 cycles
        clear_cnt();
        push(4'd1);
        repeat (6) next_cyc();
        estop = 1'b1;
        repeat (10) next_cyc();
        estop = 1'b0;
        wait_idle(300);
        chk("estop_busy", cnt_busy, 39);
        chk("estop_motor_dn", cnt_dn, 24);
        chk("estop_floor", int'(curr_floor), 1);
`endif

        // randomized request traffic
        for (int r = 0; r < 30; r++) begin
            push(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) begin
                push(4'($urandom_range(0, NF - 1)));
            end
            gap = $urandom_range(1, 60);
            for (int c = 0; c < gap; c++) begin
`ifdef LIFT_ESTOP_EN
                estop = ($urandom_range(0, 7) == 0);
`endif
                next_cyc();
            end
        end
        estop = 1'b0;
        wait_idle(6000);

        // asynchronous reset while travelling past floor 2
        push(4'd0);
        wait_idle(300);
        push(4'd4);
        n = 0;
        while ((curr_floor != 4'd2) && (n < 100)) begin
            next_cyc();
            n++;
        end
        chk("reach_floor2", int'(curr_floor), 2);
        repeat (3) next_cyc();
        push(4'd7);
        rst = 1'b1;
        #1;
        chk("rst_mid_floor", int'(curr_floor), RF);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_flags", int'({q_rd, motor_up, motor_dn, door_open, arrived, req_drop}), 0);
        exp_q.delete();
        m_floor = 4'(RF);
        next_cyc();
        rst = 1'b0;
        wait_idle(300);
        chk("after_rst_floor", int'(curr_floor), 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
